// File: rtl/axi_master_fft_feed_if.sv
// AXI4 master-side bundle (AW/W/B/AR/R) for the FFT feed engine.
// Data is fixed at 32 bits; ID and address widths are parameterised.
interface axi_master_fft_feed_if #(
  parameter int WIDTH_SID = 15,
  parameter int WIDTH_AD  = 14
);
  logic [WIDTH_SID-1:0] AWID;
  logic [WIDTH_AD-1:0]  AWADDR;
  logic [7:0]           AWLEN;
  logic [2:0]           AWSIZE;
  logic [1:0]           AWBURST;
  logic                 AWVALID;
  logic                 AWREADY;

  logic [WIDTH_SID-1:0] WID;
  logic [31:0]          WDATA;
  logic [3:0]           WSTRB;
  logic                 WLAST;
  logic                 WVALID;
  logic                 WREADY;

  logic [WIDTH_SID-1:0] BID;
  logic [1:0]           BRESP;
  logic                 BVALID;
  logic                 BREADY;

  logic [WIDTH_SID-1:0] ARID;
  logic [WIDTH_AD-1:0]  ARADDR;
  logic [7:0]           ARLEN;
  logic [2:0]           ARSIZE;
  logic [1:0]           ARBURST;
  logic                 ARVALID;
  logic                 ARREADY;

  logic [WIDTH_SID-1:0] RID;
  logic [31:0]          RDATA;
  logic [1:0]           RRESP;
  logic                 RLAST;
  logic                 RVALID;
  logic                 RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
    output WID, WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input  BID, BRESP, BVALID, output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
    input  WID, WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BID, BRESP, BVALID, input BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
  );
endinterface

// File: rtl/axi_master_fft_feed.sv
// Streams one N_PT-sample frame out as an AXI write burst, then reads the same
// region back as a read burst and forwards it to the result sink.
module axi_master_fft_feed #(
  parameter int WIDTH_SID = 15,
  parameter int WIDTH_AD  = 14,
  parameter int N_PT      = 128,
  parameter int BASE_ADDR = 0
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESETN,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  axi_master_fft_feed_if.master m_axi
);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

  localparam logic [7:0]          LAST_BEAT = 8'(N_PT - 1);
  localparam logic [WIDTH_AD-1:0] ADDR      = WIDTH_AD'(BASE_ADDR);

  state_t     state_q;
  logic [7:0] cnt_q;
  logic       err_q;
  logic       last_beat;
  logic       w_hs;
  logic       r_hs;
  logic       unused_ok;

  assign last_beat = (cnt_q == LAST_BEAT);
  assign w_hs      = (state_q == S_W) && in_valid && m_axi.WREADY;
  assign r_hs      = (state_q == S_R) && m_axi.RVALID && out_ready;
  assign unused_ok = ^{m_axi.BID, m_axi.RID};

  // Reset abandons any burst in flight; the next start begins a fresh frame.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_AW;
            err_q   <= 1'b0;
          end
        end
        S_AW: begin
          if (m_axi.AWREADY) begin
            state_q <= S_W;
            cnt_q   <= '0;
          end
        end
        S_W: begin
          if (w_hs) begin
            cnt_q <= cnt_q + 8'd1;
            if (last_beat) state_q <= S_B;
          end
        end
        S_B: begin
          if (m_axi.BVALID) begin
            if (m_axi.BRESP != 2'b00) err_q <= 1'b1;
            state_q <= S_AR;
          end
        end
        S_AR: begin
          if (m_axi.ARREADY) begin
            state_q <= S_R;
            cnt_q   <= '0;
          end
        end
        S_R: begin
          if (r_hs) begin
            cnt_q <= cnt_q + 8'd1;
            // The slave's RLAST must agree with our own beat count.
            if ((m_axi.RLAST != last_beat) || (m_axi.RRESP != 2'b00)) err_q <= 1'b1;
            if (last_beat) state_q <= S_DONE;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign err  = err_q;

  assign m_axi.AWID    = '0;
  assign m_axi.AWADDR  = ADDR;
  assign m_axi.AWLEN   = LAST_BEAT;
  assign m_axi.AWSIZE  = 3'b010;
  assign m_axi.AWBURST = 2'b01;
  assign m_axi.AWVALID = (state_q == S_AW);

  // Write data is a straight pass-through of the sample source.
  assign m_axi.WID    = '0;
  assign m_axi.WDATA  = in_data;
  assign m_axi.WSTRB  = 4'hF;
  assign m_axi.WLAST  = (state_q == S_W) && last_beat;
  assign m_axi.WVALID = (state_q == S_W) && in_valid;
  assign in_ready     = (state_q == S_W) && m_axi.WREADY;

  assign m_axi.BREADY = (state_q == S_B);

  assign m_axi.ARID    = '0;
  assign m_axi.ARADDR  = ADDR;
  assign m_axi.ARLEN   = LAST_BEAT;
  assign m_axi.ARSIZE  = 3'b010;
  assign m_axi.ARBURST = 2'b01;
  assign m_axi.ARVALID = (state_q == S_AR);

  assign m_axi.RREADY = (state_q == S_R) && out_ready;
  assign out_valid    = (state_q == S_R) && m_axi.RVALID;
  assign out_data     = m_axi.RDATA;

endmodule
